dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Load/store front end between the execute stage and the word-wide data memory. Accepts byte/halfword/word loads and stores, checks alignment and drives the memory's word address, write data and write enable. Turns sub-word stores into a read-modify-write sequence and sign/zero-extends sub-word loads. Stalls the core through a ready/valid handshake while a sequence is in flight.

## Interface
- ADDR_WIDTH, 32: byte address width on both sides.
- DATA_WIDTH, 32: word width; fixed at 4 bytes per word.
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as misaligned.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned request.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- mem_addr  out  ADDR_WIDTH  word-aligned byte address, bits [1:0] always 0.
- mem_wdata  out  DATA_WIDTH  full-word write data.
- mem_we  out  1  word write enable.
- mem_rdata  in  DATA_WIDTH  memory read data.

## Operation
- Memory contract: the memory registers mem_addr/mem_wdata/mem_we at each clk edge. Read data for the address registered at edge N is valid on mem_rdata during the cycle after edge N. A write registered at edge N commits at edge N+1. A read registered at edge N+1 or later returns the new data.
- States: IDLE, LOAD_RESP, RMW_MERGE, STORE_ACK, ERR_RESP.
- req_ready = (state==IDLE) && !rst. A request is accepted when req_valid && req_ready. Request fields are sampled only in the accept cycle and are captured into internal registers.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, or size 3.
  - No memory access; mem_we=0.
  - Next state is ERR_RESP.
- Aligned load: mem_addr={req_addr[hi:2],2'b0}, mem_we=0 → LOAD_RESP.
- Aligned word store: mem_addr set as for a load, mem_wdata=req_wdata, mem_we=1 → STORE_ACK.
- Byte/halfword store: issue a read of the word (mem_we=0) → RMW_MERGE.
- LOAD_RESP:
  - Select the lane at byte offset addr[1:0]*8 (little-endian); halfword uses offset addr[1]*16.
  - Extend per req_signed; word loads pass through.
  - resp_valid=1 → IDLE.
- RMW_MERGE: mem_wdata = mem_rdata with the addressed byte/halfword lane replaced by the low bits of the captured wdata. mem_addr = captured word address, mem_we=1 → STORE_ACK.
- STORE_ACK: resp_valid=1, resp_rdata=0, mem_we=0 → IDLE.
- ERR_RESP: resp_valid=1, resp_err=1, resp_rdata=0 → IDLE.
- Outside the issuing cycles, mem_we=0. In those cycles mem_addr holds the captured word address and mem_wdata holds the last driven value.

## Timing
- Accept in cycle A. Loads respond in A+1 and word stores acknowledge in A+1. Sub-word stores issue the write in A+1 and acknowledge in A+2. Errors respond in A+1.
- Throughput:
  - Loads, word stores and errors: one operation per 2 cycles.
  - Sub-word stores: one per 3 cycles.
  - req_ready=0 in every non-IDLE state.
- resp_valid, resp_err and resp_rdata are combinational from state and mem_rdata, and are valid only in the response cycle.
- Reset values, while rst=1 and the cycle after:
  - state=IDLE.
  - req_ready=0 during rst.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation drops the in-flight operation with no response. Reset in RMW_MERGE forces mem_we=0, so no partial write is issued.
- Back-to-back store then load to the same word is coherent with no extra stall, because the write commits before the following read is registered.

## Test plan
- Memory word 0x10 = 0x8899AABB. Load byte, signed, addr 0x12 → resp_valid in A+1, rdata 0xFFFFFF99. Same load unsigned → 0x00000099.
- Store halfword 0x1234 at 0x12 over 0x8899AABB → read at A, write at A+1 of 0x1234AABB, ack at A+2. A following word load of 0x10 returns 0x1234AABB.
- Store word 0xDEADBEEF at 0x20, then immediately load word 0x20 → load returns 0xDEADBEEF. req_ready is low exactly one cycle between the two operations.
- Load word at 0x21 and store halfword at 0x23 → each gives resp_err=1 in A+1, rdata 0, mem_we never asserted, and memory is unchanged.
- Assert rst during RMW_MERGE of a byte store → mem_we=0 that cycle, no resp_valid, target word unchanged, req_ready=1 the cycle after rst deasserts.
- Hold req_valid=1 across 6 word loads → exactly 3 accepted (one every 2 cycles), 3 resp_valid pulses, each in the cycle after its accept.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Load/store front end for a word-wide data memory: alignment checking, sub-word
// read-modify-write stores, and sign/zero extension of sub-word loads.
module dmem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD_RESP, RMW_MERGE, STORE_ACK, ERR_RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  accept;
  logic                  misaligned;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Lane extraction/extension for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
    half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_ext = {{(DATA_WIDTH-8){signed_q & byte_lane[7]}}, byte_lane};
      2'd1:    load_ext = {{(DATA_WIDTH-16){signed_q & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'd0) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    size_d     = size_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    req_ready  = (state_q == IDLE) && !rst;
    accept     = req_valid && req_ready;
    misaligned = (req_size == 2'd3) ||
                 (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    mem_addr   = addr_q;
    mem_wdata  = mem_wdata_q;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          off_d    = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata[15:0];
          mem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (misaligned)             state_d = ERR_RESP;
          else if (!req_we)           state_d = LOAD_RESP;
          else if (req_size == 2'd2) begin
            mem_wdata = req_wdata;
            mem_we    = 1'b1;
            state_d   = STORE_ACK;
          end else                    state_d = RMW_MERGE;
        end
      end
      LOAD_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = load_ext;
        state_d    = IDLE;
      end
      RMW_MERGE: begin
        mem_wdata = merged;
        mem_we    = 1'b1;
        state_d   = STORE_ACK;
      end
      STORE_ACK: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      ERR_RESP: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset suppresses any in-flight write or response, including a pending RMW write.
    if (rst) begin
      state_d    = IDLE;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_we     = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
    end
    mem_wdata_d = mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit with a registered-address
// word memory model (write commits one edge after it is registered).
module tb_dmem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem_model [0:255];
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we = 1'b0;

  dmem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory registers its inputs each edge; a registered write lands one edge later.
  always @(posedge clk) begin
    if (reg_we) mem_model[reg_addr[9:2]] <= reg_wdata;
    reg_addr  <= mem_addr;
    reg_wdata <= mem_wdata;
    reg_we    <= mem_we;
  end
  assign mem_rdata = mem_model[reg_addr[9:2]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    total++; if (req_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b want 0", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("[TB] FAIL rst_resp_valid: got %b want 0", resp_valid); else passed++;
    total++; if (mem_we !== 1'b0) $display("[TB] FAIL rst_mem_we: got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h0) $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("[TB] FAIL rst_mem_wdata: got %h want 0", mem_wdata); else passed++;
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) $display("[TB] FAIL post_rst_ready: got %b want 1", req_ready); else passed++;
    total++; if (resp_rdata !== 32'h0) $display("[TB] FAIL post_rst_rdata: got %h want 0", resp_rdata); else passed++;
    total++; if (mem_addr !== 32'h0) $display("[TB] FAIL post_rst_mem_addr: got %h want 0", mem_addr); else passed++;
    tick();
  endtask

  task automatic test_load_byte(input logic sgn, input logic [31:0] exp);
    drive(1'b0, 2'd0, sgn, 32'h12, 32'h0);
    #1;
    total++; if (req_ready !== 1'b1) $display("[TB] FAIL lb_accept_ready: got %b want 1", req_ready); else passed++;
    total++; if (mem_addr !== 32'h10) $display("[TB] FAIL lb_mem_addr: got %h want 10", mem_addr); else passed++;
    total++; if (mem_we !== 1'b0) $display("[TB] FAIL lb_mem_we: got %b want 0", mem_we); else passed++;
    tick();
    req_valid = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b1) $display("[TB] FAIL lb_resp_valid: got %b want 1", resp_valid); else passed++;
    total++; if (resp_err !== 1'b0) $display("[TB] FAIL lb_resp_err: got %b want 0", resp_err); else passed++;
    total++; if (resp_rdata !== exp) $display("[TB] FAIL lb_rdata: got %h want %h", resp_rdata, exp); else passed++;
    total++; if (req_ready !== 1'b0) $display("[TB] FAIL lb_busy_ready: got %b want 0", req_ready); else passed++;
    tick();
    total++; if (resp_valid !== 1'b0) $display("[TB] FAIL lb_single_pulse: got %b want 0", resp_valid); else passed++;
  endtask

  task automatic test_store_half;
    drive(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234);
    #1;
    total++; if (mem_we !== 1'b0) $display("[TB] FAIL sh_read_we: got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h10) $display("[TB] FAIL sh_read_addr: got %h want 10", mem_addr); else passed++;
    tick();
    req_valid = 1'b0;
    #1;
    total++; if (mem_we !== 1'b1) $display("[TB] FAIL sh_write_we: got %b want 1", mem_we); else passed++;
    total++; if (mem_wdata !== 32'h1234AABB) $display("[TB] FAIL sh_write_data: got %h want 1234aabb", mem_wdata); else passed++;
    total++; if (mem_addr !== 32'h10) $display("[TB] FAIL sh_write_addr: got %h want 10", mem_addr); else passed++;
    total++; if (resp_valid !== 1'b0) $display("[TB] FAIL sh_early_resp: got %b want 0", resp_valid); else passed++;
    tick();
    total++; if (resp_valid !== 1'b1) $display("[TB] FAIL sh_ack_valid: got %b want 1", resp_valid); else passed++;
    total++; if (resp_rdata !== 32'h0) $display("[TB] FAIL sh_ack_rdata: got %h want 0", resp_rdata); else passed++;
    total++; if (mem_we !== 1'b0) $display("[TB] FAIL sh_ack_we: got %b want 0", mem_we); else passed++;
    tick();
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    tick();
    req_valid = 1'b0;
    #1;
    total++; if (resp_rdata !== 32'h1234AABB) $display("[TB] FAIL sh_readback: got %h want 1234aabb", resp_rdata); else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    #1;
    total++; if (mem_we !== 1'b1) $display("[TB] FAIL sw_we: got %b want 1", mem_we); else passed++;
    total++; if (mem_wdata !== 32'hDEADBEEF) $display("[TB] FAIL sw_wdata: got %h want deadbeef", mem_wdata); else passed++;
    total++; if (mem_addr !== 32'h20) $display("[TB] FAIL sw_addr: got %h want 20", mem_addr); else passed++;
    tick();
    drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    #1;
    total++; if (req_ready !== 1'b0) $display("[TB] FAIL b2b_stall: got %b want 0", req_ready); else passed++;
    total++; if (resp_valid !== 1'b1) $display("[TB] FAIL sw_ack: got %b want 1", resp_valid); else passed++;
    tick();
    total++; if (req_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b want 1", req_ready); else passed++;
    tick();
    req_valid = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b1) $display("[TB] FAIL b2b_load_valid: got %b want 1", resp_valid); else passed++;
    total++; if (resp_rdata !== 32'hDEADBEEF) $display("[TB] FAIL b2b_load_rdata: got %h want deadbeef", resp_rdata); else passed++;
    tick();
  endtask

  task automatic test_misaligned(input logic we, input logic [1:0] size, input logic [31:0] addr);
    drive(we, size, 1'b0, addr, 32'h0000_FFFF);
    #1;
    total++; if (mem_we !== 1'b0) $display("[TB] FAIL mis_accept_we: got %b want 0", mem_we); else passed++;
    tick();
    req_valid = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b1) $display("[TB] FAIL mis_resp_valid: got %b want 1", resp_valid); else passed++;
    total++; if (resp_err !== 1'b1) $display("[TB] FAIL mis_resp_err: got %b want 1", resp_err); else passed++;
    total++; if (resp_rdata !== 32'h0) $display("[TB] FAIL mis_rdata: got %h want 0", resp_rdata); else passed++;
    total++; if (mem_we !== 1'b0) $display("[TB] FAIL mis_resp_we: got %b want 0", mem_we); else passed++;
    tick();
    tick();
    total++; if (mem_model[8] !== 32'hDEADBEEF) $display("[TB] FAIL mis_mem_intact: got %h want deadbeef", mem_model[8]); else passed++;
  endtask

  task automatic test_reset_rmw;
    drive(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0055);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) $display("[TB] FAIL rrmw_we: got %b want 0", mem_we); else passed++;
    total++; if (resp_valid !== 1'b0) $display("[TB] FAIL rrmw_resp: got %b want 0", resp_valid); else passed++;
    tick();
    rst = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) $display("[TB] FAIL rrmw_post_resp: got %b want 0", resp_valid); else passed++;
    total++; if (req_ready !== 1'b1) $display("[TB] FAIL rrmw_post_ready: got %b want 1", req_ready); else passed++;
    tick();
    tick();
    total++; if (mem_model[4] !== 32'h1234AABB) $display("[TB] FAIL rrmw_mem_intact: got %h want 1234aabb", mem_model[4]); else passed++;
  endtask

  task automatic test_throughput;
    int accepts = 0;
    int resps = 0;
    logic prev_acc = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (resp_valid === 1'b1) begin
        resps++;
        total++; if (prev_acc !== 1'b1) $display("[TB] FAIL tp_resp_follows_accept: cycle %0d got prev_acc %b want 1", i, prev_acc); else passed++;
        total++; if (resp_rdata !== 32'hDEADBEEF) $display("[TB] FAIL tp_rdata: got %h want deadbeef", resp_rdata); else passed++;
      end
      prev_acc = req_valid && req_ready;
      if (prev_acc) accepts++;
      tick();
    end
    req_valid = 1'b0;
    total++; if (accepts != 3) $display("[TB] FAIL tp_accepts: got %0d want 3", accepts); else passed++;
    total++; if (resps != 3) $display("[TB] FAIL tp_resps: got %0d want 3", resps); else passed++;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_model[4] = 32'h8899AABB;
    mem_model[8] = 32'h0;
    test_reset();
    test_load_byte(1'b1, 32'hFFFFFF99);
    test_load_byte(1'b0, 32'h00000099);
    test_store_half();
    test_back_to_back();
    test_misaligned(1'b0, 2'd2, 32'h21);
    test_misaligned(1'b1, 2'd1, 32'h23);
    test_reset_rmw();
    test_throughput();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
